// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and helpers for the sequential ALU.
// Build option: SEQ_ALU_MULDIV_EN enables the iterative mul/div unit.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_MUL  = 4'hA,
        ALU_MULH = 4'hB,
        ALU_DIV  = 4'hC,
        ALU_DIVU = 4'hD,
        ALU_REM  = 4'hE,
        ALU_REMU = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Multi-cycle operations are everything from MUL upwards.
    function automatic logic is_muldiv(alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response handshake bundle between issue logic and the ALU.
// master = issue/writeback side, slave = the ALU itself.
interface seq_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      opcode;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative shift-add multiplier and restoring divider sharing one
// 2*XLEN accumulator. Signed operations work on magnitudes and restore the sign
// at the end. Only instantiated when SEQ_ALU_MULDIV_EN is defined.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CYC  = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(CYC + 1);

    logic              r_busy;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    alu_op_e           r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_aOrig;
    logic              r_bZero;

    logic              w_signedOp, w_aNeg, w_bNeg, w_isMul;
    logic [XLEN-1:0]   w_aMag, w_bMag;
    logic [XLEN:0]     w_mulSum, w_divWide;
    logic [XLEN-1:0]   w_divDiff;
    logic              w_divGe;
    logic [2*XLEN-1:0] w_mulNext, w_divNext, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem;

    assign w_signedOp = op inside {ALU_MULH, ALU_DIV, ALU_REM};
    assign w_aNeg     = w_signedOp && a[XLEN-1];
    assign w_bNeg     = w_signedOp && b[XLEN-1];
    assign w_aMag     = w_aNeg ? -a : a;
    assign w_bMag     = w_bNeg ? -b : b;
    assign w_isMul    = r_op inside {ALU_MUL, ALU_MULH};

    // Multiply step: add multiplicand into the high half when the low bit is set, then shift right.
    assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};

    // Divide step: shift left one bit and subtract the divisor when the partial remainder allows it.
    assign w_divWide = r_acc[2*XLEN-1:XLEN-1];
    assign w_divGe   = w_divWide >= {1'b0, r_opnd};
    assign w_divDiff = w_divWide[XLEN-1:0] - r_opnd;
    assign w_divNext = w_divGe ? {w_divDiff, r_acc[XLEN-2:0], 1'b1}
                               : {w_divWide[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

    // Latch magnitudes at start, then run one iteration per cycle until the counter hits zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_op    <= ALU_ADD;
            r_neg   <= 1'b0;
            r_aOrig <= '0;
            r_bZero <= 1'b0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= CW'(CYC);
            r_acc   <= {{XLEN{1'b0}}, w_aMag};
            r_opnd  <= w_bMag;
            r_op    <= op;
            r_neg   <= (op == ALU_REM) ? w_aNeg : (w_aNeg ^ w_bNeg);
            r_aOrig <= a;
            r_bZero <= (b == '0);
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
                r_acc <= w_isMul ? w_mulNext : w_divNext;
            end
        end
    end

    assign done   = r_busy && (r_cnt == '0);
    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    // Pick the final value, applying the divide-by-zero conventions.
    always_comb begin
        res = '0;
        case (r_op)
            ALU_MUL:            res = w_prod[XLEN-1:0];
            ALU_MULH:           res = w_prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:  res = r_bZero ? '1 : w_quo;
            ALU_REM, ALU_REMU:  res = r_bZero ? r_aOrig : w_rem;
            default:            res = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result and optional iterative mul/div.
// Build option: define SEQ_ALU_MULDIV_EN to execute MUL..REMU; otherwise those
// opcodes complete in one cycle with a zero result.
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MULDIV_CYC = XLEN
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    alu_state_e      r_state, w_nextState;
    alu_op_e         w_op;
    logic            w_accept, w_isMd, w_mdDone;
    logic [XLEN-1:0] w_basicRes, w_mdRes, r_result;
    logic [SHW-1:0]  w_shamt;

    assign w_op    = alu_op_e'(bus.opcode);
    assign w_shamt = bus.b[SHW-1:0];

`ifdef SEQ_ALU_MULDIV_EN
    logic w_mdStart;
    assign w_isMd    = is_muldiv(w_op);
    assign w_mdStart = w_accept && w_isMd;

    seq_muldiv #(
        .XLEN (XLEN),
        .CYC  (MULDIV_CYC)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_mdStart),
        .op    (w_op),
        .a     (bus.a),
        .b     (bus.b),
        .done  (w_mdDone),
        .res   (w_mdRes)
    );
`else
    assign w_isMd   = 1'b0;
    assign w_mdDone = 1'b0;
    assign w_mdRes  = '0;
`endif

    assign bus.in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.zero      = (r_result == '0);

    // Single-cycle operations; anything not listed (mul/div when disabled) yields zero.
    always_comb begin
        w_basicRes = '0;
        case (w_op)
            ALU_ADD:  w_basicRes = bus.a + bus.b;
            ALU_SUB:  w_basicRes = bus.a - bus.b;
            ALU_AND:  w_basicRes = bus.a & bus.b;
            ALU_OR:   w_basicRes = bus.a | bus.b;
            ALU_XOR:  w_basicRes = bus.a ^ bus.b;
            ALU_SLL:  w_basicRes = bus.a << w_shamt;
            ALU_SRL:  w_basicRes = bus.a >> w_shamt;
            ALU_SRA:  w_basicRes = $signed(bus.a) >>> w_shamt;
            ALU_SLT:  w_basicRes = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_SLTU: w_basicRes = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            default:  w_basicRes = '0;
        endcase
    end

    // Next-state decision: DONE may hand off and accept a new op in the same cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_accept) w_nextState = w_isMd ? BUSY : DONE;
            BUSY: if (w_mdDone) w_nextState = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    if (w_accept) w_nextState = w_isMd ? BUSY : DONE;
                    else          w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // Result register: loaded at accept for basic ops, at completion for mul/div, else held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (w_accept && !w_isMd) begin
            r_result <= w_basicRes;
        end else if ((r_state == BUSY) && w_mdDone) begin
            r_result <= w_mdRes;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu against a behavioural
// model built from plain integer arithmetic. Honours SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int XLEN = 32;
`ifdef SEQ_ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int totalChecks = 0;
    int badChecks = 0;

    seq_alu_if #(.XLEN(XLEN)) bus();

    seq_alu #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, prodS;
        logic [63:0] prodU, prodSBits;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        prodU = {32'd0, a} * {32'd0, b};
        prodS = sa * sb;
        prodSBits = prodS;
        sh = int'(b % 32);
        if (!MD_EN && op >= 4'hA) return 32'd0;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << sh;
            4'h6: return a >> sh;
            4'h7: return 32'(sa >>> sh);
            4'h8: return (sa < sb) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            4'hA: return prodU[31:0];
            4'hB: return prodSBits[63:32];
            4'hC: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            4'hD: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'hE: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles after the accept edge before out_valid is seen.
    function automatic int refLatency(input logic [3:0] op);
        return (MD_EN && op >= 4'hA) ? XLEN + 1 : 0;
    endfunction

    // One full transaction: accept, wait for result, optional backpressure, then hand off.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        int guard;
        int lat;
        logic [31:0] exp;
        logic [31:0] held;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.opcode    = op;
        bus.a         = a;
        bus.b         = b;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            step();
            guard++;
        end
        checkOutput("inReady", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.opcode   = 4'($urandom);
        exp = refModel(op, a, b);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            step();
            lat++;
        end
        checkOutput($sformatf("latency op%0h", op), 64'(lat), 64'(refLatency(op)));
        checkOutput($sformatf("result op%0h a=%0h b=%0h", op, a, b), 64'(bus.result), 64'(exp));
        checkOutput("zero", 64'(bus.zero), 64'(exp == 0));
        held = exp;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.opcode   = 4'($urandom);
            bus.a        = $urandom;
            checkOutput("stallReady", 64'(bus.in_ready), 64'd0);
            step();
            checkOutput("stallValid", 64'(bus.out_valid), 64'd1);
            checkOutput("stallHold", 64'(bus.result), 64'(held));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        checkOutput("handoff", 64'(bus.out_valid), 64'd0);
    endtask

    // Two basic ops issued on consecutive cycles with the consumer always ready.
    task automatic backToBack();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.opcode    = ALU_ADD;
        bus.a         = 32'hFFFF_FFFF;
        bus.b         = 32'd1;
        checkOutput("b2bReadyIdle", 64'(bus.in_ready), 64'd1);
        step();
        bus.opcode = ALU_SRA;
        bus.a      = 32'h8000_0000;
        bus.b      = 32'd4;
        checkOutput("b2bValid0", 64'(bus.out_valid), 64'd1);
        checkOutput("b2bResult0", 64'(bus.result), 64'd0);
        checkOutput("b2bZero0", 64'(bus.zero), 64'd1);
        checkOutput("b2bReadyDone", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("b2bValid1", 64'(bus.out_valid), 64'd1);
        checkOutput("b2bResult1", 64'(bus.result), 64'hF800_0000);
        checkOutput("b2bZero1", 64'(bus.zero), 64'd0);
        step();
        checkOutput("b2bDrain", 64'(bus.out_valid), 64'd0);
    endtask

    // Reset while a divide is in flight must leave no trace of it.
    task automatic resetMidDiv();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.opcode    = ALU_DIV;
        bus.a         = 32'd100;
        bus.b         = 32'd7;
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        checkOutput("rstValid", 64'(bus.out_valid), 64'd0);
        checkOutput("rstResult", 64'(bus.result), 64'd0);
        checkOutput("rstZero", 64'(bus.zero), 64'd1);
        checkOutput("rstReady", 64'(bus.in_ready), 64'd1);
        repeat (40) step();
        checkOutput("rstNoLateResult", 64'(bus.out_valid), 64'd0);
        checkOutput("rstResultHeld", 64'(bus.result), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] op;
        logic [31:0] a, b;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.opcode    = '0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("[TB] reset released, MULDIV enabled=%0d", MD_EN);
        checkOutput("initValid", 64'(bus.out_valid), 64'd0);
        checkOutput("initResult", 64'(bus.result), 64'd0);
        checkOutput("initZero", 64'(bus.zero), 64'd1);
        checkOutput("initReady", 64'(bus.in_ready), 64'd1);

        resetMidDiv();
        backToBack();

        applyStimulus(ALU_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        applyStimulus(ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        applyStimulus(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        applyStimulus(ALU_DIVU, 32'd7, 32'd0, 0);
        applyStimulus(ALU_REM,  32'd7, 32'd0, 0);
        applyStimulus(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        applyStimulus(ALU_DIV,  32'd10, 32'd2, 1);
        applyStimulus(ALU_SLT,  32'hFFFF_FFFF, 32'd1, 3);
        applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0);

        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: a = 32'd0;
                2: a = 32'(-$urandom_range(1, 100));
                default: ;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(0, 31));
                default: ;
            endcase
            applyStimulus(op, a, b, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
